// File: rtl/system_sysid_checker.sv
// system_sysid_checker
//   Avalon-MM read master that reads the system ID slave (ID word at address 0,
//   timestamp word at address 1), compares both against the expected build values
//   and latches pass / fail / timeout status for the boot path.
//
//   Optional build macro: SYSID_CHECK_AUTOSTART_EN
//     defined   - a one-shot issues an implicit start on the first clock edge
//                 after reset_n deasserts.
//     undefined - checks run only on an external start pulse.
//
// Ports
//   clock, reset_n    system clock, asynchronous active-low reset
//   start             single-cycle check request, honoured only when idle
//   avm_address       0 = ID word, 1 = timestamp word
//   avm_read          read strobe
//   avm_waitrequest   slave stall
//   avm_readdata      slave read data (32 bits)
//   busy              check in progress
//   done              one-cycle pulse when status is valid
//   id_ok, ts_ok      captured words equal the expected values
//   timeout           a read stalled for TIMEOUT_CYCLES cycles
//   captured_id/ts    last ID / timestamp words read

module system_sysid_checker #(
    parameter logic [31:0] EXPECTED_ID        = 32'd0,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1395429642,
    parameter int unsigned READ_LATENCY       = 0,
    parameter int unsigned TIMEOUT_CYCLES     = 255
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout,
    output logic [31:0] captured_id,
    output logic [31:0] captured_ts
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_RD_ID  = 3'd1;
    localparam logic [2:0] S_LAT_ID = 3'd2;
    localparam logic [2:0] S_RD_TS  = 3'd3;
    localparam logic [2:0] S_LAT_TS = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    localparam bit          ZERO_LAT = (READ_LATENCY == 0);
    // Last count value: only meaningful when READ_LATENCY > 0.
    localparam logic [2:0]  LAT_LAST = 3'(READ_LATENCY - 1);
    localparam logic [15:0] TO_LAST  = 16'(TIMEOUT_CYCLES - 1);

    logic [2:0]  state_q, state_d;
    logic [2:0]  lat_q, lat_d;
    logic [15:0] to_q, to_d;
    logic        done_q, done_d;
    logic        id_ok_q, id_ok_d;
    logic        ts_ok_q, ts_ok_d;
    logic        timeout_q, timeout_d;
    logic [31:0] cap_id_q, cap_id_d;
    logic [31:0] cap_ts_q, cap_ts_d;
    logic        start_eff;

`ifdef SYSID_CHECK_AUTOSTART_EN
    logic auto_pending;

    // Set by reset, consumed by the first clock edge after release.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) auto_pending <= 1'b1;
        else          auto_pending <= 1'b0;
    end

    assign start_eff = start | auto_pending;
`else
    assign start_eff = start;
`endif

    // Strobes decode straight from state so reset removes them asynchronously.
    assign avm_read    = (state_q == S_RD_ID) || (state_q == S_RD_TS);
    assign avm_address = (state_q == S_RD_TS);
    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign id_ok       = id_ok_q;
    assign ts_ok       = ts_ok_q;
    assign timeout     = timeout_q;
    assign captured_id = cap_id_q;
    assign captured_ts = cap_ts_q;

    always_comb begin
        state_d   = state_q;
        lat_d     = lat_q;
        to_d      = to_q;
        done_d    = 1'b0;
        id_ok_d   = id_ok_q;
        ts_ok_d   = ts_ok_q;
        timeout_d = timeout_q;
        cap_id_d  = cap_id_q;
        cap_ts_d  = cap_ts_q;

        unique case (state_q)
            S_IDLE: begin
                if (start_eff) begin
                    id_ok_d   = 1'b0;
                    ts_ok_d   = 1'b0;
                    timeout_d = 1'b0;
                    cap_id_d  = '0;
                    cap_ts_d  = '0;
                    to_d      = '0;
                    lat_d     = '0;
                    state_d   = S_RD_ID;
                end
            end
            S_RD_ID, S_RD_TS: begin
                if (avm_waitrequest) begin
                    if (to_q == TO_LAST) begin
                        // Abandon: remaining reads skipped, captures kept.
                        timeout_d = 1'b1;
                        id_ok_d   = 1'b0;
                        ts_ok_d   = 1'b0;
                        done_d    = 1'b1;
                        to_d      = '0;
                        state_d   = S_DONE;
                    end else begin
                        to_d = to_q + 16'd1;
                    end
                end else begin
                    to_d  = '0;
                    lat_d = '0;
                    if (!ZERO_LAT) begin
                        state_d = (state_q == S_RD_ID) ? S_LAT_ID : S_LAT_TS;
                    end else if (state_q == S_RD_ID) begin
                        cap_id_d = avm_readdata;
                        state_d  = S_RD_TS;
                    end else begin
                        cap_ts_d = avm_readdata;
                        id_ok_d  = (cap_id_q == EXPECTED_ID);
                        ts_ok_d  = (avm_readdata == EXPECTED_TIMESTAMP);
                        done_d   = 1'b1;
                        state_d  = S_DONE;
                    end
                end
            end
            S_LAT_ID, S_LAT_TS: begin
                if (lat_q != LAT_LAST) begin
                    lat_d = lat_q + 3'd1;
                end else if (state_q == S_LAT_ID) begin
                    cap_id_d = avm_readdata;
                    state_d  = S_RD_TS;
                end else begin
                    cap_ts_d = avm_readdata;
                    id_ok_d  = (cap_id_q == EXPECTED_ID);
                    ts_ok_d  = (avm_readdata == EXPECTED_TIMESTAMP);
                    done_d   = 1'b1;
                    state_d  = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            lat_q     <= '0;
            to_q      <= '0;
            done_q    <= 1'b0;
            id_ok_q   <= 1'b0;
            ts_ok_q   <= 1'b0;
            timeout_q <= 1'b0;
            cap_id_q  <= '0;
            cap_ts_q  <= '0;
        end else begin
            state_q   <= state_d;
            lat_q     <= lat_d;
            to_q      <= to_d;
            done_q    <= done_d;
            id_ok_q   <= id_ok_d;
            ts_ok_q   <= ts_ok_d;
            timeout_q <= timeout_d;
            cap_id_q  <= cap_id_d;
            cap_ts_q  <= cap_ts_d;
        end
    end

endmodule

// File: tb/tb_system_sysid_checker.sv
// Bench for system_sysid_checker: three instances (default parameters,
// READ_LATENCY=2, TIMEOUT_CYCLES=8), each with its own slave model. Expected
// results are pushed to a scoreboard when a check is requested and popped when
// the instance pulses done.

module tb_system_sysid_checker;

    localparam logic [31:0] TS_GOOD = 32'd1395429642;
    localparam logic [31:0] JUNK    = 32'hDEADBEEF;

    typedef struct {
        string       tag;
        logic        id_ok;
        logic        ts_ok;
        logic        tmo;
        logic [31:0] cid;
        logic [31:0] cts;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [2:0] start_v = 3'b000;
    int         cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Instance 0: defaults, zero-latency slave.
    logic        d_addr, d_read, d_busy, d_done, d_idok, d_tsok, d_tmo;
    logic [31:0] d_rdata, d_cid, d_cts;
    logic [31:0] d_id_val = 32'd0;
    logic [31:0] d_ts_val = TS_GOOD;
    assign d_rdata = d_read ? (d_addr ? d_ts_val : d_id_val) : JUNK;

    system_sysid_checker u_def (
        .clock(clk), .reset_n(reset_n), .start(start_v[0]),
        .avm_address(d_addr), .avm_read(d_read), .avm_waitrequest(1'b0),
        .avm_readdata(d_rdata), .busy(d_busy), .done(d_done), .id_ok(d_idok),
        .ts_ok(d_tsok), .timeout(d_tmo), .captured_id(d_cid), .captured_ts(d_cts)
    );

    int   acc_n = 0, prev_cyc = 0, last_cyc = 0;
    logic prev_addr = 1'b0, last_addr = 1'b0;
    always @(posedge clk) begin
        if (reset_n && d_read) begin
            acc_n     <= acc_n + 1;
            prev_addr <= last_addr;
            last_addr <= d_addr;
            prev_cyc  <= last_cyc;
            last_cyc  <= cyc;
        end
    end

    // Instance 1: READ_LATENCY=2; data is valid only in the cycle it is due.
    logic        l_addr, l_read, l_wr, l_busy, l_done, l_idok, l_tsok, l_tmo;
    logic [31:0] l_rdata, l_cid, l_cts;
    logic        p1_v = 1'b0, p1_a = 1'b0, p2_v = 1'b0, p2_a = 1'b0;
    int          l_stall_cfg = 0, l_stall_left = 0, l_viol = 0;
    logic        lp_read = 1'b0, lp_wr = 1'b0, lp_addr = 1'b0;
    assign l_wr    = l_read && !l_addr && (l_stall_left > 0);
    assign l_rdata = p2_v ? (p2_a ? TS_GOOD : 32'd0) : JUNK;

    always @(posedge clk) begin
        p1_v <= l_read && !l_wr;
        p1_a <= l_addr;
        p2_v <= p1_v;
        p2_a <= p1_a;
        if (start_v[1])          l_stall_left <= l_stall_cfg;
        else if (l_read && l_wr) l_stall_left <= l_stall_left - 1;
        if (lp_read && lp_wr && (!l_read || l_addr != lp_addr)) l_viol <= l_viol + 1;
        lp_read <= l_read;
        lp_wr   <= l_wr;
        lp_addr <= l_addr;
    end

    system_sysid_checker #(.READ_LATENCY(2)) u_lat (
        .clock(clk), .reset_n(reset_n), .start(start_v[1]),
        .avm_address(l_addr), .avm_read(l_read), .avm_waitrequest(l_wr),
        .avm_readdata(l_rdata), .busy(l_busy), .done(l_done), .id_ok(l_idok),
        .ts_ok(l_tsok), .timeout(l_tmo), .captured_id(l_cid), .captured_ts(l_cts)
    );

    // Instance 2: TIMEOUT_CYCLES=8, waitrequest under bench control.
    logic        t_addr, t_read, t_busy, t_done, t_idok, t_tsok, t_tmo;
    logic        t_wr = 1'b0;
    logic [31:0] t_rdata, t_cid, t_cts;
    int          t_stalls = 0;
    logic        t_saw_a1 = 1'b0;
    assign t_rdata = t_read ? (t_addr ? TS_GOOD : 32'd0) : JUNK;

    always @(posedge clk) begin
        if (start_v[2]) begin
            t_stalls <= 0;
            t_saw_a1 <= 1'b0;
        end else begin
            if (t_read && t_wr) t_stalls <= t_stalls + 1;
            if (t_read && t_addr) t_saw_a1 <= 1'b1;
        end
    end

    system_sysid_checker #(.TIMEOUT_CYCLES(8)) u_to (
        .clock(clk), .reset_n(reset_n), .start(start_v[2]),
        .avm_address(t_addr), .avm_read(t_read), .avm_waitrequest(t_wr),
        .avm_readdata(t_rdata), .busy(t_busy), .done(t_done), .id_ok(t_idok),
        .ts_ok(t_tsok), .timeout(t_tmo), .captured_id(t_cid), .captured_ts(t_cts)
    );

    logic [2:0]  done_a, busy_a, idok_a, tsok_a, tmo_a;
    logic [31:0] cid_a[3], cts_a[3];
    assign done_a = {t_done, l_done, d_done};
    assign busy_a = {t_busy, l_busy, d_busy};
    assign idok_a = {t_idok, l_idok, d_idok};
    assign tsok_a = {t_tsok, l_tsok, d_tsok};
    assign tmo_a  = {t_tmo, l_tmo, d_tmo};
    always_comb begin
        cid_a[0] = d_cid; cid_a[1] = l_cid; cid_a[2] = t_cid;
        cts_a[0] = d_cts; cts_a[1] = l_cts; cts_a[2] = t_cts;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic iok, input logic tok, input logic tmo,
                        input logic [31:0] cid, input logic [31:0] cts, input int lat);
        exp_t e;
        e.tag = tag; e.id_ok = iok; e.ts_ok = tok; e.tmo = tmo;
        e.cid = cid; e.cts = cts; e.lat = lat;
        sb.push_back(e);
    endtask

    // Start (or, with drive=0, rely on the auto-start at the next edge), then wait
    // for done and compare against the scoreboard head. lat counts negedges after
    // the start edge, i.e. the edge at which done is first sampled high.
    task automatic run_check(input int inst, input bit drive, input int extra_at);
        exp_t e;
        int   k;
        bit   got;
        e = sb.pop_front();
        if (drive) begin
            @(negedge clk);
            start_v[inst] = 1'b1;
        end
        @(posedge clk);
        #1 start_v[inst] = 1'b0;
        k = 0;
        got = 0;
        while (!got && k < 200) begin
            @(negedge clk);
            k++;
            if (k == 1) chk({e.tag, "_busy"}, 32'(busy_a[inst]), 32'd1);
            if (k == extra_at) start_v[inst] = 1'b1;
            if (k == extra_at + 1) start_v[inst] = 1'b0;
            if (done_a[inst]) got = 1;
        end
        start_v[inst] = 1'b0;
        chk({e.tag, "_done_at"}, k, e.lat);
        chk({e.tag, "_id_ok"}, 32'(idok_a[inst]), 32'(e.id_ok));
        chk({e.tag, "_ts_ok"}, 32'(tsok_a[inst]), 32'(e.ts_ok));
        chk({e.tag, "_timeout"}, 32'(tmo_a[inst]), 32'(e.tmo));
        chk({e.tag, "_cap_id"}, cid_a[inst], e.cid);
        chk({e.tag, "_cap_ts"}, cts_a[inst], e.cts);
        @(negedge clk);
        chk({e.tag, "_done_pulse"}, 32'(done_a[inst]), 32'd0);
        chk({e.tag, "_busy_end"}, 32'(busy_a[inst]), 32'd0);
    endtask

    task automatic release_reset(input string tag);
        @(negedge clk);
        reset_n = 1'b1;
`ifdef SYSID_CHECK_AUTOSTART_EN
        push({tag, "_auto"}, 1'b1, 1'b1, 1'b0, 32'd0, TS_GOOD, 3);
        run_check(0, 1'b0, -5);
        repeat (20) @(negedge clk);
        chk({tag, "_auto_idle"}, 32'(busy_a), 32'd0);
`else
        repeat (5) @(negedge clk);
        chk({tag, "_no_autorun"}, 32'(busy_a), 32'd0);
`endif
    endtask

    initial begin : main
        int base;

        // Reset state.
        #12;
        chk("rst_read", 32'({t_read, l_read, d_read}), 32'd0);
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_status", 32'({done_a, idok_a, tsok_a, tmo_a}), 32'd0);
        chk("rst_cap", d_cid | d_cts | l_cid | l_cts | t_cid | t_cts, 32'd0);
        release_reset("rst");

        // Matching build, zero latency, no stalls.
        base = acc_n;
        push("basic", 1'b1, 1'b1, 1'b0, 32'd0, TS_GOOD, 3);
        run_check(0, 1'b1, -5);
        chk("basic_nreads", acc_n - base, 32'd2);
        chk("basic_addr_seq", 32'({prev_addr, last_addr}), 32'b01);
        chk("basic_consec", last_cyc - prev_cyc, 32'd1);

        // Timestamp mismatch.
        d_ts_val = 32'h12345678;
        push("ts_bad", 1'b1, 1'b0, 1'b0, 32'd0, 32'h12345678, 3);
        run_check(0, 1'b1, -5);

        // ID mismatch, timestamp good.
        d_ts_val = TS_GOOD;
        d_id_val = 32'h0000_0001;
        push("id_bad", 1'b0, 1'b1, 1'b0, 32'h0000_0001, TS_GOOD, 3);
        run_check(0, 1'b1, -5);
        d_id_val = 32'd0;

        // Extra start while busy is ignored; exactly two reads, no second run.
        base = acc_n;
        push("extra_start", 1'b1, 1'b1, 1'b0, 32'd0, TS_GOOD, 3);
        run_check(0, 1'b1, 1);
        repeat (5) @(negedge clk);
        chk("extra_start_idle", 32'(d_busy), 32'd0);
        chk("extra_start_nreads", acc_n - base, 32'd2);

        // 4-cycle stall on address 0 with READ_LATENCY=2 on both reads.
        l_stall_cfg = 4;
        push("lat_stall", 1'b1, 1'b1, 1'b0, 32'd0, TS_GOOD, 3 + 4 + 2 * 2);
        run_check(1, 1'b1, -5);
        chk("lat_stall_stable", l_viol, 32'd0);

        // Stuck waitrequest: abandon after 8 stall cycles, timestamp never read.
        t_wr = 1'b1;
        push("timeout", 1'b0, 1'b0, 1'b1, 32'd0, 32'd0, 8 + 1);
        run_check(2, 1'b1, -5);
        chk("timeout_stalls", t_stalls, 32'd8);
        chk("timeout_no_addr1", 32'(t_saw_a1), 32'd0);

        // Reset mid-read clears everything asynchronously.
        @(negedge clk);
        start_v[2] = 1'b1;
        @(negedge clk);
        start_v[2] = 1'b0;
        repeat (2) @(negedge clk);
        chk("midrst_reading", 32'(t_read), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("midrst_read", 32'(t_read), 32'd0);
        chk("midrst_busy", 32'(busy_a), 32'd0);
        chk("midrst_ok", 32'({idok_a, tsok_a}), 32'd0);
        chk("midrst_cap", d_cts, 32'd0);
        t_wr = 1'b0;
        release_reset("midrst");

        // Timeout instance runs normally on a fresh start.
        push("to_normal", 1'b1, 1'b1, 1'b0, 32'd0, TS_GOOD, 3);
        run_check(2, 1'b1, -5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
